// File: rtl/instr_loader_pkg.sv
// Shared definitions for the byte-stream instruction loader:
// FSM state encoding and word/lane geometry.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_e;

  localparam int LANE_W         = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_pack.sv
// Byte packer: lane counter plus four byte registers that assemble one
// little-endian word; clearing zeroes every lane so a short final word is zero-filled.
module instr_loader_pack
  import instr_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [LANE_W-1:0] lane,
  output logic [7:0]        data1,
  output logic [7:0]        data2,
  output logic [7:0]        data3,
  output logic [7:0]        data4
);

  logic [BYTES_PER_WORD-1:0][7:0] bytes_q, bytes_d;
  logic [LANE_W-1:0]              lane_q, lane_d;

  always_comb begin
    bytes_d = bytes_q;
    lane_d  = lane_q;
    if (clear) begin
      bytes_d = '0;
      lane_d  = '0;
    end else if (accept) begin
      bytes_d[lane_q] = byte_data;
      lane_d          = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bytes_q <= '0;
      lane_q  <= '0;
    end else begin
      bytes_q <= bytes_d;
      lane_q  <= lane_d;
    end
  end

  assign lane  = lane_q;
  assign data1 = bytes_q[0];
  assign data2 = bytes_q[1];
  assign data3 = bytes_q[2];
  assign data4 = bytes_q[3];

endmodule

// File: rtl/instr_loader.sv
// Program loader: packs a byte stream into words, writes them to instruction
// memory and releases the CPU when done. Optional byte checksum: LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           MAX_WORDS   = 20000,
  parameter int unsigned           COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [7:0]             mem_data1,
  output logic [7:0]             mem_data2,
  output logic [7:0]             mem_data3,
  output logic [7:0]             mem_data4,
  output logic                   mem_we,
  output logic                   mem_enable,
  output logic                   cpu_reset,
  output logic                   cpu_en,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [31:0]            checksum
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]  wc_q, wc_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    last_q, last_d;
  logic                    byte_ready_q, byte_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_en_q, mem_en_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    cpu_en_q, cpu_en_d;
  logic                    xfer;
  logic                    pack_clear;
  logic [LANE_W-1:0]       lane;

  // byte_ready_q is only ever high in COLLECT, so this is the full handshake
  assign xfer = byte_valid & byte_ready_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    done_d     = done_q;
    error_d    = error_q;
    last_d     = last_q;
    pack_clear = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = COLLECT;
          addr_d     = BASE_ADDR;
          wc_d       = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          last_d     = 1'b0;
          pack_clear = 1'b1;
        end
      end
      COLLECT: begin
        if (xfer) begin
          last_d = byte_last;
          if (byte_last || lane == LANE_W'(BYTES_PER_WORD - 1))
            state_d = WRITE;
        end
      end
      WRITE: begin
        if (wc_q != '1)
          wc_d = wc_q + 1'b1;
        // end of image wins over the capacity check on the final word
        if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if ((32'(wc_q) + 32'd1) == MAX_WORDS) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          state_d    = COLLECT;
          addr_d     = addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
          pack_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Control outputs are registered from the next state so they align with state_q
    byte_ready_d = (state_d == COLLECT);
    mem_we_d     = (state_d == WRITE);
    mem_en_d     = (state_d == COLLECT) || (state_d == WRITE);
    cpu_reset_d  = (state_d != DONE);
    cpu_en_d     = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      wc_q         <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      last_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      cpu_reset_q  <= 1'b1;
      cpu_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wc_q         <= wc_d;
      done_q       <= done_d;
      error_q      <= error_d;
      last_q       <= last_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_en_q     <= mem_en_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_en_q     <= cpu_en_d;
    end
  end

  instr_loader_pack u_pack (
    .clock     (clock),
    .reset     (reset),
    .clear     (pack_clear),
    .accept    (xfer),
    .byte_data (byte_data),
    .lane      (lane),
    .data1     (mem_data1),
    .data2     (mem_data2),
    .data3     (mem_data3),
    .data4     (mem_data4)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  logic        csum_clear;

  assign csum_clear = start &&
                      (state_q == IDLE || state_q == DONE || state_q == ERROR);

  // Transfers only happen in COLLECT, so the sum is frozen in DONE and ERROR
  always_comb begin
    csum_d = csum_q;
    if (csum_clear)
      csum_d = '0;
    else if (xfer)
      csum_d = csum_q + {24'h0, byte_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      csum_q <= '0;
    else
      csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign byte_ready = byte_ready_q;
  assign mem_addr   = addr_q;
  assign mem_we     = mem_we_q;
  assign mem_enable = mem_en_q;
  assign cpu_reset  = cpu_reset_q;
  assign cpu_en     = cpu_en_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected memory writes are queued by the
// stimulus and checked by a monitor on every mem_we strobe.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data1, mem_data2, mem_data3, mem_data4;
  logic        mem_we, mem_enable, cpu_reset, cpu_en, done, error;
  logic [15:0] word_count;
  logic [31:0] checksum;

  always #5 clock = ~clock;

  instr_loader #(
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (32'h0),
    .MAX_WORDS   (2),
    .COUNT_WIDTH (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data1  (mem_data1),
    .mem_data2  (mem_data2),
    .mem_data3  (mem_data3),
    .mem_data4  (mem_data4),
    .mem_we     (mem_we),
    .mem_enable (mem_enable),
    .cpu_reset  (cpu_reset),
    .cpu_en     (cpu_en),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .checksum   (checksum)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back('{addr: addr, data: data});
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 mem_addr, {mem_data4, mem_data3, mem_data2, mem_data1});
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", mem_addr, mon_e.addr);
        check("write_data", {mem_data4, mem_data3, mem_data2, mem_data1}, mon_e.data);
        check("write_enable", {31'h0, mem_enable}, 32'h1);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int unsigned waited = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    while (byte_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (byte_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_ready_timeout: byte %h not accepted, got ready=%b, expected 1", d, byte_ready);
    end else begin
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  // Called #1 after the edge that accepted the final byte
  task automatic finish_check(input logic [15:0] exp_wc);
    check("we_in_write", {31'h0, mem_we}, 32'h1);
    check("cpu_reset_in_write", {31'h0, cpu_reset}, 32'h1);
    @(posedge clock);
    #1;
    check("done_flag", {31'h0, done}, 32'h1);
    check("cpu_en_done", {31'h0, cpu_en}, 32'h1);
    check("cpu_reset_done", {31'h0, cpu_reset}, 32'h0);
    check("word_count_done", {16'h0, word_count}, {16'h0, exp_wc});
    check("error_clear_done", {31'h0, error}, 32'h0);
    check("we_after_write", {31'h0, mem_we}, 32'h0);
    check("ready_in_done", {31'h0, byte_ready}, 32'h0);
  endtask

  function automatic logic [31:0] exp_csum(input logic [31:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] img1 [8];
    img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h08, 8'hD0, 8'h05};
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    #12;
    check("rst_addr", mem_addr, 32'h0);
    check("rst_data", {mem_data4, mem_data3, mem_data2, mem_data1}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_enable", {31'h0, mem_enable}, 32'h0);
    check("rst_ready", {31'h0, byte_ready}, 32'h0);
    check("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    check("rst_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    check("rst_word_count", {16'h0, word_count}, 32'h0);
    check("rst_checksum", checksum, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // 1: two full words, streamed with valid every cycle
    @(negedge clock);
    pulse_start();
    check("ready_after_start", {31'h0, byte_ready}, 32'h1);
    check("enable_collect", {31'h0, mem_enable}, 32'h1);
    expect_write(32'h0, 32'h00000013);
    expect_write(32'h4, 32'h05D00893);
    for (int i = 0; i < 8; i++) send_byte(img1[i], (i == 7));
    finish_check(16'd2);
    check("csum_t1", checksum, exp_csum(32'h183));

    // bytes offered in DONE must not be taken
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (3) @(negedge clock);
    check("ready_held_low_done", {31'h0, byte_ready}, 32'h0);
    byte_valid = 1'b0;
    check("wc_after_idle_bytes", {16'h0, word_count}, 32'h2);
    check("csum_frozen_done", checksum, exp_csum(32'h183));

    // 2: partial final word, with an ignored start mid-collect
    @(negedge clock);
    pulse_start();
    check("done_cleared", {31'h0, done}, 32'h0);
    check("wc_cleared", {16'h0, word_count}, 32'h0);
    expect_write(32'h0, 32'hDDCCBBAA);
    expect_write(32'h4, 32'h000000EE);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pulse_start();
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b1);
    finish_check(16'd2);

    // 3: valid toggling every other cycle
    @(negedge clock);
    pulse_start();
    expect_write(32'h0, 32'h44332211);
    send_byte(8'h11, 1'b0);
    @(posedge clock); #1;
    send_byte(8'h22, 1'b0);
    @(posedge clock); #1;
    send_byte(8'h33, 1'b0);
    @(posedge clock); #1;
    send_byte(8'h44, 1'b1);
    finish_check(16'd1);

    // 4: capacity overflow with MAX_WORDS=2
    @(negedge clock);
    pulse_start();
    expect_write(32'h0, 32'h04030201);
    expect_write(32'h4, 32'h08070605);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    check("we_last_word", {31'h0, mem_we}, 32'h1);
    @(posedge clock); #1;
    check("error_flag", {31'h0, error}, 32'h1);
    check("error_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("error_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    check("error_done", {31'h0, done}, 32'h0);
    check("error_wc", {16'h0, word_count}, 32'h2);
    check("error_enable", {31'h0, mem_enable}, 32'h0);
    byte_valid = 1'b1;
    byte_data  = 8'h09;
    repeat (4) @(negedge clock);
    check("error_ready", {31'h0, byte_ready}, 32'h0);
    byte_valid = 1'b0;
    check("csum_error", checksum, exp_csum(32'h24));

    // 5: asynchronous reset mid-word, then a fresh load
    @(negedge clock);
    pulse_start();
    check("error_cleared", {31'h0, error}, 32'h0);
    expect_write(32'h0, 32'h0D0C0B0A);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'h0E, 1'b0);
    send_byte(8'h0F, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_cpu_reset", {31'h0, cpu_reset}, 32'h1);
    check("abort_ready", {31'h0, byte_ready}, 32'h0);
    check("abort_enable", {31'h0, mem_enable}, 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_we", {31'h0, mem_we}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse_start();

    // 6: checksum image
    expect_write(32'h0, 32'hFFFF0201);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b1);
    finish_check(16'd1);
    check("csum_t6", checksum, exp_csum(32'h201));

    repeat (3) @(negedge clock);
    check("pending_writes", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Byte-stream program loader and the write-side counterpart of the CPU's instruction fetch path. It accepts a little-endian program image one byte at a time over a valid/ready stream. It packs each group of four bytes into a word and writes the word into the instruction memory's four byte lanes (data1..data4). While loading, it holds the CPU stopped; once the image is complete, it releases the CPU to run from BASE_ADDR.

Parameters:
ADDR_WIDTH, 32, width of the byte address driven to instruction memory (matches pc)
BASE_ADDR, 32'h0, byte address of the first word written
MAX_WORDS, 20000, instruction memory capacity in words; exceeding it is an error
COUNT_WIDTH, 16, width of word_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
start  in  1  single-cycle pulse that begins a load
byte_valid  in  1  stream byte present
byte_data  in  8  stream byte
byte_last  in  1  qualifies the final byte of the image
byte_ready  out  1  loader accepts byte this cycle
mem_addr  out  ADDR_WIDTH  word-aligned byte address to instruction memory
mem_data1  out  8  byte at mem_addr+0
mem_data2  out  8  byte at mem_addr+1
mem_data3  out  8  byte at mem_addr+2
mem_data4  out  8  byte at mem_addr+3
mem_we  out  1  instruction memory write strobe
mem_enable  out  1  instruction memory enable, high in COLLECT and WRITE
cpu_reset  out  1  held high except in DONE
cpu_en  out  1  high only in DONE
done  out  1  load completed successfully; sticky
error  out  1  overflow occurred; sticky
word_count  out  COUNT_WIDTH  number of words written in the current load
checksum  out  32  see Optional Feature

Behaviour:
- Reset values: state=IDLE, mem_addr=BASE_ADDR, mem_data1..4=0, mem_we=0, mem_enable=0, byte_ready=0, cpu_reset=1, cpu_en=0, done=0, error=0, word_count=0, lane=0.
- Handshake: a byte transfers on a rising edge where byte_valid & byte_ready. byte_ready is registered and high only in COLLECT. byte_data must be stable while byte_valid is high. byte_last is sampled only on a transfer.
- States:
  - IDLE: on start, clear word_count, done, error and checksum; set mem_addr=BASE_ADDR and lane=0; go to COLLECT.
  - COLLECT: each transfer stores the byte in lane (0->mem_data1 ... 3->mem_data4) and increments lane.
    - If lane==3 or byte_last: go to WRITE.
    - Unwritten lanes of a partial final word are zero-filled.
  - WRITE: mem_we=1 for exactly one cycle, with mem_addr and the data stable; increment word_count. Next state:
    - DONE if the captured byte_last was 1.
    - ERROR if word_count+1==MAX_WORDS and the image has not ended.
    - COLLECT otherwise, with mem_addr+=4, lane=0 and data registers cleared.
  - DONE: cpu_reset=0, cpu_en=1, done=1. Stays in DONE until start (which returns to the IDLE->COLLECT path) or reset.
  - ERROR: error=1, cpu_reset=1, byte_ready=0. Left only by start or reset.
- Timing: one word costs 4 accept cycles plus 1 WRITE cycle, so a byte stream that is valid every cycle sustains 4 of every 5 cycles. The first byte_ready rises the cycle after start.
- Boundaries:
  - start outside IDLE, DONE or ERROR is ignored.
  - byte_valid outside COLLECT is not accepted.
  - byte_last on lane 0 produces a word containing 1 byte plus 3 zero bytes.
  - mem_addr wraps modulo 2^ADDR_WIDTH. This cannot happen before MAX_WORDS is reached with the default parameters.
  - An asynchronous reset mid-load abandons the partial word with no write; cpu_reset=1 takes effect immediately.
  - word_count saturates at 2^COUNT_WIDTH-1.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: checksum holds the 32-bit modular sum of every accepted byte (zero-extended). It is cleared on start and reset, and frozen in DONE and ERROR.
- Undefined: checksum is tied to 32'h0 and no accumulator logic is built.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=0, COLLECT=1, WRITE=2, DONE=3, ERROR=4, 3 bits wide
  - lane index width: 2
  - BYTES_PER_WORD=4
- One natural sub-module: instr_loader_pack. It contains the lane counter, the four byte registers, zero-fill and clear; instr_loader instantiates it next to the FSM.

Test Plan:
1. Bytes 13,00,00,00,93,08,D0,05 with byte_last on the 8th byte -> two writes: addr 0 data 00000013, addr 4 data 05D00893; word_count=2, done=1, cpu_reset falls the cycle after the second WRITE.
2. 5-byte image AA,BB,CC,DD,EE (last on EE) -> second write at addr 4 with mem_data1=EE and mem_data2..4=00; done=1.
3. byte_valid toggling every other cycle over 4 bytes -> exactly one mem_we pulse, data correct, no duplicated or dropped bytes.
4. MAX_WORDS=2 with a 12-byte stream -> two writes, then error=1, byte_ready=0, cpu_en=0, no third write.
5. Reset asserted after 2 bytes of the second word -> immediate IDLE, mem_we never pulses for that word, cpu_reset=1. A new start reloads from BASE_ADDR.
6. With LOADER_CHECKSUM_EN, bytes 01,02,FF,FF -> checksum=32'h201. Without the macro -> checksum=0.
